// File: rtl/alu_result_stage.sv
// Two-entry result FIFO between the ALU and writeback. It computes status flags when an
// entry is pushed, and on retirement updates the architectural carry/borrow flags and the op counter.
module alu_result_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      result_i,
   input  logic             carry_i,
   input  logic             borrow_i,
   input  logic [4:0]       selector_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_result_o,
   output logic [4:0]       out_selector_o,
   output logic [4:0]       out_flags_o,
   output logic             carry_flag_o,
   output logic             borrow_flag_o,
   output logic [CNT_W-1:0] op_count_o
);

   localparam int DATA_W = 32;
   localparam int SEL_W  = 5;
   localparam int FLG_W  = 5;

   localparam logic [SEL_W-1:0] SEL_ADD     = 5'd0;
   localparam logic [SEL_W-1:0] SEL_SUB     = 5'd1;
   localparam logic [SEL_W-1:0] SEL_MAX_LEG = 5'd12;

   // Flag word {illegal, borrow, carry, negative, zero}
   function automatic logic [FLG_W-1:0] calc_flags(
      input logic [DATA_W-1:0] res,
      input logic              carry,
      input logic              borrow,
      input logic [SEL_W-1:0]  sel
   );
      return {(sel > SEL_MAX_LEG), borrow, carry, res[DATA_W-1], (res == '0)};
   endfunction

   // Control state
   logic [1:0]       occ_q, occ_d;
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic             in_ready_q, in_ready_d;
   logic             carry_flag_q, carry_flag_d;
   logic             borrow_flag_q, borrow_flag_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   // Entry storage
   logic [DATA_W-1:0] res_mem_q [2];
   logic [DATA_W-1:0] res_mem_d [2];
   logic [SEL_W-1:0]  sel_mem_q [2];
   logic [SEL_W-1:0]  sel_mem_d [2];
   logic [FLG_W-1:0]  flg_mem_q [2];
   logic [FLG_W-1:0]  flg_mem_d [2];

   logic push, pop, valid;

   assign valid = (occ_q != 2'd0);
   assign push  = in_valid_i & in_ready_q;
   assign pop   = valid & out_ready_i;

   always_comb begin
      occ_d         = occ_q;
      head_d        = head_q;
      tail_d        = tail_q;
      carry_flag_d  = carry_flag_q;
      borrow_flag_d = borrow_flag_q;
      op_count_d    = op_count_q;
      res_mem_d     = res_mem_q;
      sel_mem_d     = sel_mem_q;
      flg_mem_d     = flg_mem_q;

      if (push) begin
         res_mem_d[tail_q] = result_i;
         sel_mem_d[tail_q] = selector_i;
         flg_mem_d[tail_q] = calc_flags(result_i, carry_i, borrow_i, selector_i);
         tail_d            = ~tail_q;
      end

      if (pop) begin
         head_d     = ~head_q;
         op_count_d = op_count_q + 1'b1;
         if (sel_mem_q[head_q] == SEL_ADD)
            carry_flag_d = flg_mem_q[head_q][2];
         else if (sel_mem_q[head_q] == SEL_SUB)
            borrow_flag_d = flg_mem_q[head_q][3];
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      // Ready is registered: it reflects occupancy after this edge
      in_ready_d = (occ_d < 2'd2);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q         <= '0;
         head_q        <= 1'b0;
         tail_q        <= 1'b0;
         in_ready_q    <= 1'b0;
         carry_flag_q  <= 1'b0;
         borrow_flag_q <= 1'b0;
         op_count_q    <= '0;
      end else begin
         occ_q         <= occ_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         in_ready_q    <= in_ready_d;
         carry_flag_q  <= carry_flag_d;
         borrow_flag_q <= borrow_flag_d;
         op_count_q    <= op_count_d;
      end
   end

   // Storage is never written while in_ready is low, so it needs no reset
   always_ff @(posedge clk_i) begin
      res_mem_q <= res_mem_d;
      sel_mem_q <= sel_mem_d;
      flg_mem_q <= flg_mem_d;
   end

   assign in_ready_o     = in_ready_q;
   assign out_valid_o    = valid;
   assign out_result_o   = valid ? res_mem_q[head_q] : '0;
   assign out_selector_o = valid ? sel_mem_q[head_q] : '0;
   assign out_flags_o    = valid ? flg_mem_q[head_q] : '0;
   assign carry_flag_o   = carry_flag_q;
   assign borrow_flag_o  = borrow_flag_q;
   assign op_count_o     = op_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: table of single-entry push/pop vectors plus
// hand-written sequences for full FIFO, concurrent push/pop, reset and counter wrap.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] result_i;
   logic        carry_i;
   logic        borrow_i;
   logic [4:0]  selector_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_result_o;
   logic [4:0]  out_selector_o;
   logic [4:0]  out_flags_o;
   logic        carry_flag_o;
   logic        borrow_flag_o;
   logic [15:0] op_count_o;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;

   alu_result_stage #(.CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .result_i(result_i), .carry_i(carry_i), .borrow_i(borrow_i),
      .selector_i(selector_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_result_o(out_result_o), .out_selector_o(out_selector_o),
      .out_flags_o(out_flags_o),
      .carry_flag_o(carry_flag_o), .borrow_flag_o(borrow_flag_o),
      .op_count_o(op_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  sel;
      logic        c;
      logic        b;
      logic [4:0]  flags;
      logic        cf_after;
      logic        bf_after;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_push(input logic [31:0] r, input logic [4:0] s, input logic c, input logic b);
      in_valid_i = 1'b1;
      result_i   = r;
      selector_i = s;
      carry_i    = c;
      borrow_i   = b;
   endtask

   initial begin
      // {result, selector, carry_in, borrow_in, expected flags, carry_flag after pop, borrow_flag after pop}
      vecs[0] = '{32'h0000_0000, 5'd0,  1'b1, 1'b0, 5'b00101, 1'b1, 1'b0};
      vecs[1] = '{32'h8000_0000, 5'd1,  1'b0, 1'b1, 5'b01010, 1'b1, 1'b1};
      vecs[2] = '{32'h1234_5678, 5'd13, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b1};
      vecs[3] = '{32'hFFFF_FFFF, 5'd0,  1'b0, 1'b1, 5'b01010, 1'b0, 1'b1};
      vecs[4] = '{32'h0000_0001, 5'd1,  1'b1, 1'b0, 5'b00100, 1'b0, 1'b0};
      vecs[5] = '{32'h0000_0000, 5'd31, 1'b1, 1'b1, 5'b11101, 1'b0, 1'b0};
      vecs[6] = '{32'h7FFF_FFFF, 5'd12, 1'b1, 1'b0, 5'b00100, 1'b0, 1'b0};
      vecs[7] = '{32'h0000_0005, 5'd2,  1'b0, 1'b0, 5'b00000, 1'b0, 1'b0};

      rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
      result_i = '0; selector_i = '0; carry_i = 1'b0; borrow_i = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_carry", carry_flag_o, 0);
      chk("rst_borrow", borrow_flag_o, 0);
      chk("rst_count", op_count_o, 0);
      chk("rst_result", out_result_o, 0);
      chk("rst_flags", out_flags_o, 0);
      chk("rst_selector", out_selector_o, 0);
      rst_i = 1'b0;
      tick();
      chk("rel_in_ready", in_ready_o, 1);

      // Pop while empty is ignored
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      chk("empty_pop_count", op_count_o, 0);
      chk("empty_pop_valid", out_valid_o, 0);

      // Table vectors: push one entry, inspect head, pop, inspect architectural state
      for (int i = 0; i < 8; i++) begin
         drive_push(vecs[i].res, vecs[i].sel, vecs[i].c, vecs[i].b);
         tick();
         in_valid_i = 1'b0;
         chk($sformatf("v%0d_valid", i), out_valid_o, 1);
         chk($sformatf("v%0d_result", i), out_result_o, vecs[i].res);
         chk($sformatf("v%0d_selector", i), out_selector_o, vecs[i].sel);
         chk($sformatf("v%0d_flags", i), out_flags_o, vecs[i].flags);
         out_ready_i = 1'b1;
         tick();
         out_ready_i = 1'b0;
         exp_cnt++;
         chk($sformatf("v%0d_carry_flag", i), carry_flag_o, vecs[i].cf_after);
         chk($sformatf("v%0d_borrow_flag", i), borrow_flag_o, vecs[i].bf_after);
         chk($sformatf("v%0d_count", i), op_count_o, exp_cnt);
         chk($sformatf("v%0d_empty", i), out_valid_o, 0);
      end

      // Fill to two entries; a third push attempt is refused
      drive_push(32'h8000_0000, 5'd2, 1'b0, 1'b0);
      tick();
      chk("full1_in_ready", in_ready_o, 1);
      drive_push(32'h0000_0005, 5'd3, 1'b0, 1'b0);
      tick();
      chk("full2_in_ready", in_ready_o, 0);
      drive_push(32'hDEAD_BEEF, 5'd4, 1'b0, 1'b0);
      tick();
      in_valid_i = 1'b0;
      chk("full_in_ready_hold", in_ready_o, 0);
      chk("full_head", out_result_o, 32'h8000_0000);
      chk("full_head_neg", out_flags_o[1], 1);
      out_ready_i = 1'b1;
      tick();
      chk("full_pop1_head", out_result_o, 32'h0000_0005);
      chk("full_pop1_selector", out_selector_o, 5'd3);
      chk("full_pop1_in_ready", in_ready_o, 1);
      tick();
      out_ready_i = 1'b0;
      exp_cnt += 2;
      chk("full_pop2_valid", out_valid_o, 0);
      chk("full_pop2_count", op_count_o, exp_cnt);

      // Concurrent push and pop at occupancy 1
      drive_push(32'h0000_00AA, 5'd5, 1'b0, 1'b0);
      tick();
      drive_push(32'h0000_00BB, 5'd6, 1'b0, 1'b0);
      out_ready_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      exp_cnt++;
      chk("pp_valid", out_valid_o, 1);
      chk("pp_head", out_result_o, 32'h0000_00BB);
      chk("pp_in_ready", in_ready_o, 1);
      chk("pp_count", op_count_o, exp_cnt);
      tick();
      out_ready_i = 1'b0;
      exp_cnt++;
      chk("pp_drain_valid", out_valid_o, 0);
      chk("pp_drain_count", op_count_o, exp_cnt);

      // Reset with two entries held discards them
      drive_push(32'h0000_0011, 5'd0, 1'b1, 1'b1);
      tick();
      drive_push(32'h0000_0022, 5'd1, 1'b1, 1'b1);
      tick();
      in_valid_i = 1'b0;
      chk("pre_rst_in_ready", in_ready_o, 0);
      rst_i = 1'b1;
      out_ready_i = 1'b1;
      tick();
      chk("mid_rst_valid", out_valid_o, 0);
      chk("mid_rst_in_ready", in_ready_o, 0);
      chk("mid_rst_carry", carry_flag_o, 0);
      chk("mid_rst_borrow", borrow_flag_o, 0);
      rst_i = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready_o, 1);
      chk("post_rst_count", op_count_o, 0);
      chk("post_rst_valid", out_valid_o, 0);
      out_ready_i = 1'b0;

      // Counter wrap: stream 65536 entries through, one pop per cycle
      drive_push(32'h0000_0001, 5'd2, 1'b0, 1'b0);
      out_ready_i = 1'b1;
      tick();
      repeat (65535) tick();
      chk("wrap_count_max", op_count_o, 16'hFFFF);
      chk("wrap_valid", out_valid_o, 1);
      in_valid_i = 1'b0;
      tick();
      out_ready_i = 1'b0;
      chk("wrap_count_zero", op_count_o, 0);
      chk("wrap_empty", out_valid_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
